// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction memory byte pointer and
// registers the fetched 16-bit word for decode, with stall, redirect, halt and fault handling.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       MEM_BYTES = 100,
  parameter logic [3:0]        HALT_OPC  = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] pointer,
  input  logic [15:0]       instr_in,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [15:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              halted,
  output logic              fault
);

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned EXT_W   = ADDR_W + 1;
  localparam logic [EXT_W-1:0] MEM_LIMIT = EXT_W'(MEM_BYTES);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_out_q, instr_out_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic                instr_valid_q, instr_valid_d;
  logic                halted_q, halted_d;
  logic                fault_q, fault_d;

  logic [EXT_W-1:0]    pc_last_byte;
  logic [EXT_W-1:0]    tgt_last_byte;
  logic                pc_out_of_range;
  logic                tgt_illegal;

  // A fetch reads two bytes, so the second byte address must still be inside memory.
  always_comb begin
    pc_last_byte    = {1'b0, pc_q} + EXT_W'(1);
    tgt_last_byte   = {1'b0, redirect_target} + EXT_W'(1);
    pc_out_of_range = (pc_last_byte >= MEM_LIMIT);
    tgt_illegal     = redirect_target[0] || (tgt_last_byte >= MEM_LIMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
    end
  end

  // Next-state: redirect beats stall, stall beats the bounds check, bounds check beats capture.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    fault_d       = fault_q;

    unique case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          instr_valid_d = 1'b0;
          if (tgt_illegal) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d = redirect_target;
          end
        end else if (stall) begin
          // hold everything
        end else if (pc_out_of_range) begin
          state_d       = ST_FAULT;
          fault_d       = 1'b1;
          instr_valid_d = 1'b0;
        end else begin
          instr_out_d   = instr_in;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + ADDR_W'(2);
          if (instr_in[15:12] == HALT_OPC) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
        end
      end
      ST_HALT: begin
        // The halt word is retired once decode accepts it.
        if (!stall) begin
          instr_valid_d = 1'b0;
        end
      end
      ST_FAULT: begin
        fault_d       = 1'b1;
        instr_valid_d = 1'b0;
      end
      default: begin
        state_d       = ST_FAULT;
        fault_d       = 1'b1;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  assign pointer     = pc_q;
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: byte memory model with the boot image,
// hand-computed expectations for run, stall, redirect, halt, fault and reset.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned MEM_BYTES = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] pointer;
  logic [15:0]       instr_in;
  logic              stall = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_target = '0;
  logic [15:0]       instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              halted;
  logic              fault;

  logic [7:0] mem [0:MEM_BYTES-1];

  int checks   = 0;
  int failures = 0;

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (16'h0000),
    .MEM_BYTES(MEM_BYTES),
    .HALT_OPC (4'hF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pointer        (pointer),
    .instr_in       (instr_in),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .halted         (halted),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  assign instr_in = (32'(pointer) + 32'd1 < MEM_BYTES) ? {mem[pointer], mem[pointer + 16'd1]} : 16'h0000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input int addr, input logic [15:0] w);
    mem[addr]     = w[15:8];
    mem[addr + 1] = w[7:0];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    stall = 1'b0;
    #1;
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_out", 32'(instr_out), 32'h0);
    check_eq("rst_pc", 32'(instr_pc), 32'h0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_ptr", 32'(pointer), 32'h0);
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [15:0] w, input logic [15:0] pc);
    check_eq({tag, "_out"}, 32'(instr_out), 32'(w));
    check_eq({tag, "_pc"}, 32'(instr_pc), 32'(pc));
    check_eq({tag, "_valid"}, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'(i);
    put_word(16'h0000, 16'h0E20);
    put_word(16'h0002, 16'h0B21);
    put_word(16'h0004, 16'h2388);
    put_word(16'h0006, 16'h149A);
    put_word(16'h001A, 16'hA694);
    put_word(16'h003C, 16'h0CD0);
    put_word(16'h003E, 16'hF000);

    // Boot and free run
    do_reset();
    tick(); expect_word("c1", 16'h0E20, 16'h0000);
    tick(); expect_word("c2", 16'h0B21, 16'h0002);
    tick(); expect_word("c3", 16'h2388, 16'h0004);
    check_eq("c3_ptr", 32'(pointer), 32'h6);

    // Stall holds everything
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_word("stall", 16'h2388, 16'h0004);
      check_eq("stall_ptr", 32'(pointer), 32'h6);
    end
    stall = 1'b0;
    tick(); expect_word("release", 16'h149A, 16'h0006);

    // Redirect wins over stall
    redirect_valid = 1'b1; redirect_target = 16'h001A; stall = 1'b1;
    tick();
    check_eq("redir_flush", 32'(instr_valid), 32'd0);
    check_eq("redir_ptr", 32'(pointer), 32'h1A);
    redirect_valid = 1'b0; stall = 1'b0;
    tick(); expect_word("redir_tgt", 16'hA694, 16'h001A);

    // Redirect into halt sequence
    redirect_valid = 1'b1; redirect_target = 16'h003C;
    tick();
    check_eq("r3c_flush", 32'(instr_valid), 32'd0);
    redirect_valid = 1'b0;
    tick(); expect_word("r3c", 16'h0CD0, 16'h003C);
    check_eq("r3c_halted", 32'(halted), 32'd0);
    tick(); expect_word("halt", 16'hF000, 16'h003E);
    check_eq("halt_flag", 32'(halted), 32'd1);
    check_eq("halt_ptr", 32'(pointer), 32'h40);
    stall = 1'b1;
    tick();
    check_eq("halt_stall_valid", 32'(instr_valid), 32'd1);
    stall = 1'b0;
    tick();
    check_eq("halt_drop_valid", 32'(instr_valid), 32'd0);
    check_eq("halt_ptr_frozen", 32'(pointer), 32'h40);
    redirect_valid = 1'b1; redirect_target = 16'h001A;
    tick();
    redirect_valid = 1'b0;
    tick();
    check_eq("halt_ign_ptr", 32'(pointer), 32'h40);
    check_eq("halt_ign_valid", 32'(instr_valid), 32'd0);
    check_eq("halt_ign_halted", 32'(halted), 32'd1);

    // Misaligned redirect faults and sticks
    do_reset();
    tick(); expect_word("boot2", 16'h0E20, 16'h0000);
    redirect_valid = 1'b1; redirect_target = 16'h0003;
    tick();
    check_eq("odd_fault", 32'(fault), 32'd1);
    check_eq("odd_valid", 32'(instr_valid), 32'd0);
    redirect_valid = 1'b0;
    tick(); tick();
    check_eq("odd_sticky", 32'(fault), 32'd1);
    check_eq("odd_ptr_frozen", 32'(pointer), 32'h2);
    check_eq("odd_valid2", 32'(instr_valid), 32'd0);

    // Last legal word, then range fault
    do_reset();
    redirect_valid = 1'b1; redirect_target = 16'h0062;
    tick();
    check_eq("r62_fault", 32'(fault), 32'd0);
    check_eq("r62_ptr", 32'(pointer), 32'h62);
    redirect_valid = 1'b0;
    tick(); expect_word("r62", 16'h6263, 16'h0062);
    check_eq("r62_ptr2", 32'(pointer), 32'h64);
    tick();
    check_eq("end_fault", 32'(fault), 32'd1);
    check_eq("end_valid", 32'(instr_valid), 32'd0);

    // Out-of-range redirect faults immediately
    do_reset();
    redirect_valid = 1'b1; redirect_target = 16'h0064;
    tick();
    check_eq("r64_fault", 32'(fault), 32'd1);
    check_eq("r64_valid", 32'(instr_valid), 32'd0);
    redirect_valid = 1'b0;

    // Reset mid-stream then resume from zero
    do_reset();
    tick(); expect_word("mid_c1", 16'h0E20, 16'h0000);
    tick(); expect_word("mid_c2", 16'h0B21, 16'h0002);
    rst = 1'b1;
    #1;
    check_eq("async_valid", 32'(instr_valid), 32'd0);
    check_eq("async_out", 32'(instr_out), 32'h0);
    check_eq("async_ptr", 32'(pointer), 32'h0);
    tick();
    rst = 1'b0;
    tick(); expect_word("resume", 16'h0E20, 16'h0000);
    check_eq("resume_fault", 32'(fault), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Read-side master for the byte-addressed instruction memory.
- Owns the program counter (PC) and drives the memory byte pointer.
- Registers the combinational 16-bit instruction word into a one-entry fetch register for the decode stage.
- Handles stall, branch/jump redirect with flush, halt detection and address-fault trapping.

Parameters:
- ADDR_W, 16, width of PC and memory pointer.
- RESET_PC, 16'h0000, PC value loaded on reset; must be even.
- MEM_BYTES, 100, instruction memory depth in bytes; legal fetch requires PC+1 < MEM_BYTES.
- HALT_OPC, 4'hF, opcode (instr[15:12]) treated as halt.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- pointer  output  ADDR_W  byte address to instruction memory; equals the current PC, combinationally.
- instr_in  input  16  instruction word from memory: {Mem[pointer], Mem[pointer+1]}, valid in the same cycle.
- stall  input  1  downstream not ready; hold all state.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  ADDR_W  new PC for the redirect.
- instr_out  output  16  registered instruction.
- instr_pc  output  ADDR_W  byte address instr_out was fetched from.
- instr_valid  output  1  instr_out holds a live instruction.
- halted  output  1  halt instruction fetched; fetch stopped.
- fault  output  1  misaligned or out-of-range fetch address.

Behaviour:
- Reset (async, rst=1):
  - PC=RESET_PC; state=RUN.
  - instr_out=16'h0000, instr_pc=0, instr_valid=0, halted=0, fault=0.
  - Reset mid-operation discards the fetch register and any pending redirect immediately.
- States: RUN, HALT, FAULT. Outputs are registered; pointer is the only combinational output.
- Priority order in RUN on each clk edge:
  1. redirect_valid=1:
     - If redirect_target is odd, or redirect_target+1 >= MEM_BYTES: state=FAULT, fault=1, instr_valid=0.
     - Otherwise: PC=redirect_target, instr_valid=0 (flush the wrong-path word).
     - Redirect wins over stall in both cases.
  2. stall=1: PC, instr_out, instr_pc and instr_valid all hold.
  3. PC+1 >= MEM_BYTES: state=FAULT, fault=1, instr_valid=0, no capture.
  4. Otherwise capture:
     - instr_out=instr_in, instr_pc=PC, instr_valid=1, PC=PC+2 (mod 2^ADDR_W).
     - If instr_in[15:12]==HALT_OPC: the halt word is captured normally, then state=HALT, halted=1, and PC holds at the address after the halt.
- HALT:
  - No further captures; PC frozen.
  - The halt word stays presented until a cycle with stall=0, then instr_valid=0.
  - redirect_valid is ignored. Exit only via rst.
- FAULT:
  - Sticky; fault=1, instr_valid=0, PC frozen, all inputs ignored. Exit only via rst.
- Throughput and latency:
  - One instruction per cycle when not stalled.
  - Latency from PC update to instr_valid is one cycle.
  - The first instr_valid appears on the first clk edge after rst deasserts.
  - After a redirect, instr_valid=0 for exactly one cycle, then the target instruction appears.
- pointer never takes an odd value in RUN. PC wrap at 2^ADDR_W is unreachable because the bounds check traps first.

Test Plan:
- Reset then free-run with the standard boot image, stall=0:
  - Cycle 1: instr_out=16'h0E20, instr_pc=0.
  - Cycle 2: 16'h0B21, instr_pc=2.
  - Cycle 3: 16'h2388, instr_pc=4.
  - instr_valid=1 throughout.
- Stall for 3 cycles after the word at 0x0004 is captured:
  - instr_out holds 16'h2388, instr_pc holds 0x0004, pointer holds 0x0006.
  - Next cycle after release captures 16'h149A.
- redirect_valid=1 with target 0x001A, asserted together with stall=1:
  - Next cycle instr_valid=0.
  - Following cycle instr_out=16'hA694, instr_pc=0x001A.
- Redirect to 0x003C, then run:
  - Capture 16'h0CD0, then 16'hF000 at 0x003E.
  - halted=1, PC=0x0040; instr_valid drops after one unstalled cycle.
  - A later redirect is ignored.
- Redirect to 0x0003 -> fault=1, instr_valid=0, sticky until rst.
- Redirect to 0x0062 -> legal capture; PC then 0x0064 -> fault=1 next cycle.
- Separately, redirect to 0x0064 -> immediate fault.
- Assert rst for one cycle mid-stream -> all outputs at their reset values immediately; fetch resumes from 0x0000.
